// File: rtl/four_bit_divider.sv
`default_nettype none
// ============================================================================
//  Module      : four_bit_divider
//  Description : Sequential restoring divider. Divides an 8-bit dividend by a
//                4-bit divisor and produces one quotient bit per clock. Uses a
//                start/busy/done handshake. A zero divisor completes on the
//                accepting edge with a saturated quotient.
//  Revision    : 1.0 - initial release
// ============================================================================
module four_bit_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] rem_q,   rem_d;     // partial remainder R
    logic [7:0] shf_q,   shf_d;     // dividend shifting out, quotient shifting in
    logic [3:0] dvs_q,   dvs_d;     // captured divisor V
    logic [2:0] cnt_q,   cnt_d;     // iteration counter
    logic [7:0] quot_q,  quot_d;
    logic [3:0] remo_q,  remo_d;
    logic       dbz_q,   dbz_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [4:0] w_trial;
    logic [4:0] w_diff;
    logic       w_fits;
    logic [4:0] w_new_rem;
    logic [7:0] w_new_shf;

    // Datapath for a single iteration, evaluated from the current registers.
    always_comb begin
        w_trial   = {rem_q[3:0], shf_q[7]};
        w_fits    = (w_trial >= {1'b0, dvs_q});
        w_diff    = w_trial - {1'b0, dvs_q};
        w_new_rem = w_fits ? w_diff : w_trial;
        w_new_shf = {shf_q[6:0], w_fits};
    end

    // Next-state and register-update logic; results only move on completion.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        shf_d   = shf_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == 4'd0) begin
                        // Zero divisor finishes immediately with a saturated quotient.
                        quot_d  = 8'hFF;
                        remo_d  = dividend[3:0];
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = 5'd0;
                        shf_d   = dividend;
                        dvs_d   = divisor;
                        cnt_d   = 3'd0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = w_new_rem;
                shf_d = w_new_shf;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    quot_d  = w_new_shf;
                    remo_d  = w_new_rem[3:0];
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            // DONE lasts one cycle and does not accept a new request.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= 5'd0;
            shf_q   <= 8'd0;
            dvs_q   <= 4'd0;
            cnt_q   <= 3'd0;
            quot_q  <= 8'd0;
            remo_q  <= 4'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            shf_q   <= shf_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_four_bit_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_four_bit_divider
//  Description : Self-checking bench for four_bit_divider against an
//                arithmetic reference (integer divide / modulo).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_four_bit_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    // Last completed result, which the outputs must hold between completions.
    logic [7:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_z;

    four_bit_divider dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division, with the saturating zero-divisor rule.
    task automatic ref_div(input logic [7:0] dd, input logic [3:0] dv,
                           output logic [7:0] q, output logic [3:0] r);
        if (dv == 4'd0) begin
            q = 8'hFF;
            r = dd[3:0];
        end else begin
            q = dd / {4'd0, dv};
            r = 4'(dd % {4'd0, dv});
        end
    endtask

    // One complete operation with full cycle-by-cycle handshake checking.
    task automatic do_op(input logic [7:0] dd, input logic [3:0] dv, input string tag);
        logic [7:0] q;
        logic [3:0] r;
        ref_div(dd, dv, q, r);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        step();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        chk({tag, "_busy_k"}, busy, 1);
        if (dv == 4'd0) begin
            chk({tag, "_done_k"}, done, 1);
            chk({tag, "_q"}, quotient, q);
            chk({tag, "_r"}, remainder, r);
            chk({tag, "_dbz"}, div_by_zero, 1);
            exp_q = q; exp_r = r; exp_z = 1'b1;
            step();
            chk({tag, "_done_k1"}, done, 0);
            chk({tag, "_busy_k1"}, busy, 0);
        end else begin
            chk({tag, "_done_k"}, done, 0);
            for (int i = 1; i < 8; i++) begin
                step();
                chk({tag, "_busy_run"}, busy, 1);
                chk({tag, "_done_run"}, done, 0);
                chk({tag, "_q_hold"}, quotient, exp_q);
                chk({tag, "_r_hold"}, remainder, exp_r);
                chk({tag, "_z_hold"}, div_by_zero, exp_z);
            end
            step();
            chk({tag, "_done_k8"}, done, 1);
            chk({tag, "_busy_k8"}, busy, 1);
            chk({tag, "_q"}, quotient, q);
            chk({tag, "_r"}, remainder, r);
            chk({tag, "_dbz"}, div_by_zero, 0);
            chk({tag, "_inv"}, 32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
            chk({tag, "_r_lt_d"}, 32'(remainder < dv), 1);
            exp_q = q; exp_r = r; exp_z = 1'b0;
            step();
            chk({tag, "_done_k9"}, done, 0);
            chk({tag, "_busy_k9"}, busy, 0);
        end
    endtask

    initial begin
        logic [7:0] dd_now;
        logic [3:0] dv_now;
        logic [7:0] pq;
        logic [3:0] pr;
        logic       pz;
        int         free_at;
        int         due;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        step();
        step();
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        exp_q = 8'd0; exp_r = 4'd0; exp_z = 1'b0;
        rst_n = 1'b1;
        step();

        // Directed cases including boundary quotients and zero divisor.
        do_op(8'd200, 4'd7,  "d200_7");
        do_op(8'd255, 4'd1,  "d255_1");
        do_op(8'd14,  4'd15, "d14_15");
        do_op(8'd5,   4'd0,  "d5_0");
        do_op(8'd143, 4'd11, "d143_11");

        // Reset in the middle of a running operation.
        start    = 1'b1;
        dividend = 8'd143;
        divisor  = 4'd11;
        step();                         // edge k
        start = 1'b0;
        step(); step(); step();         // edges k+1..k+3
        rst_n = 1'b0;
        step();                         // edge k+4
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        chk("midrst_dbz", div_by_zero, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst_n = 1'b1;
        exp_q = 8'd0; exp_r = 4'd0; exp_z = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("midrst_no_done", done, 0);
        end
        do_op(8'd100, 4'd9, "d100_9");

        // Reset and start on the same edge: reset wins.
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
        step();
        chk("rststart_busy", busy, 0);
        chk("rststart_q", quotient, 0);
        rst_n = 1'b1;
        start = 1'b0;
        exp_q = 8'd0; exp_r = 4'd0; exp_z = 1'b0;
        step();
        chk("rststart_idle", busy, 0);

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 4'($urandom), "rand");
        end

        // Start held high with inputs changing every cycle. Abstract model:
        // a request is taken whenever the unit is free; completion arrives
        // 8 edges later (0 for a zero divisor) and the unit frees two edges
        // after completion.
        free_at = 0;
        due     = -1;
        for (int e = 0; e < 70; e++) begin
            start    = (e < 50);
            dd_now   = 8'($urandom);
            dv_now   = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            dividend = dd_now;
            divisor  = dv_now;
            step();
            if (start && e >= free_at) begin
                ref_div(dd_now, dv_now, pq, pr);
                pz      = (dv_now == 4'd0);
                due     = e + ((dv_now == 4'd0) ? 0 : 8);
                free_at = due + 2;
            end
            chk("held_done", done, (e == due) ? 1 : 0);
            if (e == due) begin
                chk("held_q", quotient, pq);
                chk("held_r", remainder, pr);
                chk("held_dbz", div_by_zero, pz);
                exp_q = pq; exp_r = pr; exp_z = pz;
            end
        end
        start = 1'b0;
        step();
        chk("held_idle", busy, 0);

        // Exhaustive sweep of all input pairs.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(8'(a), 4'(b), "sweep");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
